// File: rtl/p_modarith_vec.sv
// p_modarith_vec
// -----------------------------------------------------------------------------
// Pipelined multi-lane modular arithmetic unit over GF(P).
// Each accepted cycle processes LANES independent operand pairs with one of
// add, subtract, accumulate or negate. Every result is reduced into [0, P-1].
// One vector is accepted per cycle, and results appear two cycles later.
//
// Parameters:
//   WIDTH  bits per field element (P < 2**WIDTH)
//   P      field modulus (2 <= P < 2**WIDTH)
//   LANES  number of independent lanes
//
// Ports:
//   i_clk      clock
//   i_rst      synchronous active-high reset
//   i_start    operation valid this cycle
//   i_mode     00 add, 01 sub, 10 accumulate, 11 negate
//   i_acc_clr  clear all lane accumulators
//   in_1       operand A, lane k at [k*WIDTH +: WIDTH]
//   in_2       operand B, same packing (unused by accumulate and negate)
//   out        registered result vector, same packing
//   o_done     out is valid this cycle (one pulse per operation)
// -----------------------------------------------------------------------------
module p_modarith_vec #(
    parameter int WIDTH = 8,
    parameter int P     = 251,
    parameter int LANES = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [1:0]               i_mode,
    input  logic                     i_acc_clr,
    input  logic [LANES*WIDTH-1:0]   in_1,
    input  logic [LANES*WIDTH-1:0]   in_2,
    output logic [LANES*WIDTH-1:0]   out,
    output logic                     o_done
);

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_ACC = 2'b10,
        MODE_NEG = 2'b11
    } mode_t;

    localparam logic [WIDTH:0] P_EXT = (WIDTH+1)'(P);

    mode_t op_mode;
    logic  acc_op;

    logic [LANES-1:0][WIDTH:0]   a_ext;
    logic [LANES-1:0][WIDTH:0]   b_ext;
    logic [LANES-1:0][WIDTH:0]   acc_base;
    logic [LANES-1:0][WIDTH:0]   acc_sum;
    logic [LANES-1:0][WIDTH-1:0] acc_next;
    logic [LANES-1:0][WIDTH:0]   raw_d;

    logic [LANES-1:0][WIDTH-1:0] acc_q;
    logic [LANES-1:0][WIDTH:0]   s1_raw;
    logic                        s1_valid;
    mode_t                       s1_mode;

    logic [LANES-1:0][WIDTH-1:0] fixed;

    assign op_mode = mode_t'(i_mode);
    assign acc_op  = i_start && (op_mode == MODE_ACC);

    // Stage-1 raw results, one WIDTH+1 bit value per lane.
    // Add keeps the carry, sub and negate keep the borrow in the top bit.
    // Negate is computed as 0 - a so it shares the subtract correction.
    // The accumulator path is fully reduced here, so back-to-back
    // accumulates see the updated value with no bubble.
    // A clear in the same cycle as an accumulate zeroes the old value
    // before the add.
    always_comb begin
        a_ext    = '0;
        b_ext    = '0;
        acc_base = '0;
        acc_sum  = '0;
        acc_next = '0;
        raw_d    = '0;
        for (int k = 0; k < LANES; k++) begin
            a_ext[k]    = {1'b0, in_1[k*WIDTH +: WIDTH]};
            b_ext[k]    = {1'b0, in_2[k*WIDTH +: WIDTH]};
            acc_base[k] = i_acc_clr ? '0 : {1'b0, acc_q[k]};
            acc_sum[k]  = acc_base[k] + a_ext[k];
            acc_next[k] = (acc_sum[k] >= P_EXT) ? WIDTH'(acc_sum[k] - P_EXT)
                                                : acc_sum[k][WIDTH-1:0];
            case (op_mode)
                MODE_ADD: raw_d[k] = a_ext[k] + b_ext[k];
                MODE_SUB: raw_d[k] = a_ext[k] - b_ext[k];
                MODE_NEG: raw_d[k] = '0 - a_ext[k];
                MODE_ACC: raw_d[k] = {1'b0, acc_next[k]};
            endcase
        end
    end

    // Stage-2 single correction. Sums, including the already-reduced
    // accumulator value, lose P when they reach it. Differences that
    // borrowed get P added back. For canonical inputs one step is enough.
    always_comb begin
        fixed = '0;
        for (int k = 0; k < LANES; k++) begin
            if ((s1_mode == MODE_SUB) || (s1_mode == MODE_NEG)) begin
                fixed[k] = s1_raw[k][WIDTH] ? WIDTH'(s1_raw[k] + P_EXT)
                                            : s1_raw[k][WIDTH-1:0];
            end else begin
                fixed[k] = (s1_raw[k] >= P_EXT) ? WIDTH'(s1_raw[k] - P_EXT)
                                                : s1_raw[k][WIDTH-1:0];
            end
        end
    end

    // Pipeline and accumulator registers.
    // Reset drops everything in flight, including a start in the same cycle.
    // The accumulators change only on an accumulate or a clear.
    // out only loads when a valid result arrives, so it holds between results.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q    <= '0;
            s1_raw   <= '0;
            s1_valid <= 1'b0;
            s1_mode  <= MODE_ADD;
            out      <= '0;
            o_done   <= 1'b0;
        end else begin
            s1_valid <= i_start;
            s1_raw   <= raw_d;
            s1_mode  <= op_mode;
            if (acc_op) begin
                acc_q <= acc_next;
            end else if (i_acc_clr) begin
                acc_q <= '0;
            end
            o_done <= s1_valid;
            if (s1_valid) begin
                out <= fixed;
            end
        end
    end

endmodule

// File: tb/tb_p_modarith_vec.sv
// tb_p_modarith_vec
// -----------------------------------------------------------------------------
// Self-checking bench for p_modarith_vec.
// The default instance is WIDTH=8, P=251, LANES=4. Two extra instances cover
// WIDTH=13, P=8191, LANES=1 and WIDTH=2, P=2, LANES=1.
// Expected values come from the directed results and from a plain-arithmetic
// modular model with per-lane accumulator state.
// -----------------------------------------------------------------------------
module tb_p_modarith_vec;

    localparam int W  = 8;
    localparam int P  = 251;
    localparam int L  = 4;
    localparam int VW = W * L;
    localparam int W2 = 13;
    localparam int P2 = 8191;
    localparam int W3 = 2;
    localparam int P3 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic          acc_clr;
    logic [VW-1:0] in_1;
    logic [VW-1:0] in_2;
    logic [VW-1:0] out;
    logic          done;

    logic          w_start;
    logic [1:0]    w_mode;
    logic          w_clr;
    logic [W2-1:0] w_a;
    logic [W2-1:0] w_b;
    logic [W2-1:0] w_out;
    logic          w_done;

    logic          t_start;
    logic [1:0]    t_mode;
    logic          t_clr;
    logic [W3-1:0] t_a;
    logic [W3-1:0] t_b;
    logic [W3-1:0] t_out;
    logic          t_done;

    int checks = 0;
    int errors = 0;
    int acc_m[L];
    logic [VW-1:0] exp_q[$];

    p_modarith_vec #(.WIDTH(W), .P(P), .LANES(L)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode),
        .i_acc_clr(acc_clr), .in_1(in_1), .in_2(in_2), .out(out), .o_done(done)
    );

    p_modarith_vec #(.WIDTH(W2), .P(P2), .LANES(1)) dut_wide (
        .i_clk(clk), .i_rst(rst), .i_start(w_start), .i_mode(w_mode),
        .i_acc_clr(w_clr), .in_1(w_a), .in_2(w_b), .out(w_out), .o_done(w_done)
    );

    p_modarith_vec #(.WIDTH(W3), .P(P3), .LANES(1)) dut_p2 (
        .i_clk(clk), .i_rst(rst), .i_start(t_start), .i_mode(t_mode),
        .i_acc_clr(t_clr), .in_1(t_a), .in_2(t_b), .out(t_out), .o_done(t_done)
    );

    // Field arithmetic for the non-accumulate modes, straight from the math.
    function automatic int ref_op(int m, int a, int b, int p);
        case (m)
            0:       return (a + b) % p;
            1:       return (a - b + p) % p;
            3:       return (p - a) % p;
            default: return 0;
        endcase
    endfunction

    function automatic logic [VW-1:0] pack4(int l0, int l1, int l2, int l3);
        logic [VW-1:0] v;
        v = '0;
        v[0*W +: W] = W'(l0);
        v[1*W +: W] = W'(l1);
        v[2*W +: W] = W'(l2);
        v[3*W +: W] = W'(l3);
        return v;
    endfunction

    function automatic logic [VW-1:0] rep(int x);
        return pack4(x, x, x, x);
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < L; k++) v[k*W +: W] = W'($urandom_range(P - 1));
        return v;
    endfunction

    // Drives one cycle on the main instance and updates the model.
    // The expected vector is queued for every start.
    task automatic drive_op(input logic s, input logic [1:0] m, input logic c,
                            input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0] e;
        int ak, bk, base;
        start = s; mode = m; acc_clr = c; in_1 = a; in_2 = b;
        e = '0;
        for (int k = 0; k < L; k++) begin
            ak = int'(a[k*W +: W]);
            bk = int'(b[k*W +: W]);
            if (s && m == 2'b10) begin
                base = c ? 0 : acc_m[k];
                acc_m[k] = (base + ak) % P;
                e[k*W +: W] = W'(acc_m[k]);
            end else begin
                if (s) e[k*W +: W] = W'(ref_op(int'(m), ak, bk, P));
                if (c) acc_m[k] = 0;
            end
        end
        if (s) exp_q.push_back(e);
    endtask

    task automatic drive_idle();
        start = 1'b0; mode = 2'b00; acc_clr = 1'b0; in_1 = '0; in_2 = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; mode = 2'b00; acc_clr = 1'b1;
        in_1 = rand_vec(); in_2 = rand_vec();
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
        checks++; if (out !== '0) begin errors++; $display("[TB] FAIL reset_out: got %0h expected 0", out); end
        checks++; if (w_done !== 1'b0 || w_out !== '0) begin errors++; $display("[TB] FAIL reset_wide: got done %0b out %0h expected 0 0", w_done, w_out); end
        checks++; if (t_done !== 1'b0 || t_out !== '0) begin errors++; $display("[TB] FAIL reset_p2: got done %0b out %0h expected 0 0", t_done, t_out); end
        rst = 1'b0;
        drive_idle();
        for (int k = 0; k < L; k++) acc_m[k] = 0;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_add();
        drive_op(1'b1, 2'b00, 1'b0, pack4(200, 250, 0, 1), pack4(100, 250, 0, 250));
        @(negedge clk); drive_idle();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL add_early: got %0b expected 0", done); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL add_done: got %0b expected 1", done); end
        checks++; if (out !== pack4(49, 249, 0, 0)) begin errors++; $display("[TB] FAIL add_out: got %0h expected %0h", out, pack4(49, 249, 0, 0)); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL add_pulse: got %0b expected 0", done); end
        checks++; if (out !== pack4(49, 249, 0, 0)) begin errors++; $display("[TB] FAIL add_hold: got %0h expected %0h", out, pack4(49, 249, 0, 0)); end
        exp_q.delete();
    endtask

    task automatic test_sub();
        drive_op(1'b1, 2'b01, 1'b0, pack4(3, 10, 0, 7), pack4(10, 3, 250, 7));
        @(negedge clk); drive_idle();
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL sub_done: got %0b expected 1", done); end
        checks++; if (out !== pack4(244, 7, 1, 0)) begin errors++; $display("[TB] FAIL sub_out: got %0h expected %0h", out, pack4(244, 7, 1, 0)); end
        exp_q.delete();
    endtask

    task automatic test_negate();
        drive_op(1'b1, 2'b11, 1'b0, pack4(0, 1, 250, 125), rand_vec());
        @(negedge clk);
        drive_op(1'b1, 2'b11, 1'b0, pack4(0, 1, 250, 125), rand_vec());
        @(negedge clk); drive_idle();
        for (int i = 0; i < 2; i++) begin
            checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL neg_done%0d: got %0b expected 1", i, done); end
            checks++; if (out !== pack4(0, 250, 1, 126)) begin errors++; $display("[TB] FAIL neg_out%0d: got %0h expected %0h", i, out, pack4(0, 250, 1, 126)); end
            @(negedge clk);
        end
        exp_q.delete();
    endtask

    task automatic test_acc_chain();
        int ev[7]  = '{0, 0, 250, 249, 248, 30, 247};
        for (int i = 0; i < 8; i++) begin
            if (i >= 2 && i < 7) begin
                checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL chain_done%0d: got %0b expected 1", i, done); end
                checks++; if (out !== rep(ev[i])) begin errors++; $display("[TB] FAIL chain_out%0d: got %0h expected %0h", i, out, rep(ev[i])); end
            end
            case (i)
                0:       drive_op(1'b1, 2'b10, 1'b1, rep(250), rand_vec());
                1, 2, 4: drive_op(1'b1, 2'b10, 1'b0, rep(250), rand_vec());
                3:       drive_op(1'b1, 2'b00, 1'b0, rep(10), rep(20));
                default: drive_idle();
            endcase
            @(negedge clk);
        end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL chain_end: got %0b expected 0", done); end
        exp_q.delete();
    endtask

    task automatic test_acc_clr();
        int ev[8]  = '{0, 0, 0, 7, 3, 9, 4, 0};
        bit ed[8]  = '{0, 0, 0, 1, 1, 1, 1, 0};
        for (int i = 0; i < 8; i++) begin
            if (i >= 2) begin
                checks++; if (done !== ed[i]) begin errors++; $display("[TB] FAIL clr_done%0d: got %0b expected %0b", i, done, ed[i]); end
                if (ed[i]) begin
                    checks++; if (out !== rep(ev[i])) begin errors++; $display("[TB] FAIL clr_out%0d: got %0h expected %0h", i, out, rep(ev[i])); end
                end
            end
            case (i)
                0:       drive_op(1'b0, 2'b10, 1'b1, rep(100), '0);
                1:       drive_op(1'b1, 2'b10, 1'b0, rep(7), '0);
                2:       drive_op(1'b1, 2'b00, 1'b1, rep(1), rep(2));
                3:       drive_op(1'b1, 2'b10, 1'b0, rep(9), '0);
                4:       drive_op(1'b1, 2'b10, 1'b1, rep(4), '0);
                default: drive_idle();
            endcase
            @(negedge clk);
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] e;
        int pulses = 0;
        exp_q.delete();
        for (int i = 0; i < 66; i++) begin
            if (i >= 2) begin
                checks++;
                if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done%0d: got %0b expected 1", i, done); end
                else pulses++;
                e = exp_q.pop_front();
                checks++; if (out !== e) begin errors++; $display("[TB] FAIL b2b_out%0d: got %0h expected %0h", i, out, e); end
            end
            if (i < 64) drive_op(1'b1, 2'($urandom_range(3)), ($urandom_range(7) == 0), rand_vec(), rand_vec());
            else drive_idle();
            @(negedge clk);
        end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_tail: got %0b expected 0", done); end
        checks++; if (pulses != 64) begin errors++; $display("[TB] FAIL b2b_pulses: got %0d expected 64", pulses); end
    endtask

    task automatic test_reset_midflight();
        exp_q.delete();
        drive_op(1'b1, 2'b10, 1'b0, rep(100), '0);
        @(negedge clk);
        rst = 1'b1; start = 1'b1; mode = 2'b10; acc_clr = 1'b0; in_1 = rep(50);
        for (int k = 0; k < L; k++) acc_m[k] = 0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0; drive_idle();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL mid_done_n2: got %0b expected 0", done); end
        checks++; if (out !== '0) begin errors++; $display("[TB] FAIL mid_out_n2: got %0h expected 0", out); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL mid_done_n3: got %0b expected 0", done); end
        drive_op(1'b1, 2'b10, 1'b0, rep(5), '0);
        @(negedge clk); drive_idle();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL mid_done_n4: got %0b expected 0", done); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL mid_done_n5: got %0b expected 1", done); end
        checks++; if (out !== rep(5)) begin errors++; $display("[TB] FAIL mid_acc_n5: got %0h expected %0h", out, rep(5)); end
        exp_q.delete();
    endtask

    task automatic test_sweep();
        int dm[9] = '{0, 0, 1, 1, 3, 3, 2, 2, 2};
        int da[9] = '{8190, 100, 3, 0, 0, 1, 8190, 8190, 1};
        int db[9] = '{8190, 200, 10, 8190, 5, 5, 0, 0, 0};
        int dc[9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
        int tr[3] = '{0, 1, 3};
        int wm[$], wa[$], wb[$], wc[$], wq[$];
        int tm[$], ta[$], tv[$], tc[$], tq[$];
        int w_acc = 0, t_acc = 0, base, ev, n;
        foreach (dm[j]) begin
            wm.push_back(dm[j]); wa.push_back(da[j]); wb.push_back(db[j]); wc.push_back(dc[j]);
        end
        repeat (16) begin
            wm.push_back(int'($urandom_range(3)));
            wa.push_back(int'($urandom_range(P2 - 1)));
            wb.push_back(int'($urandom_range(P2 - 1)));
            wc.push_back(int'($urandom_range(3) == 0));
        end
        foreach (tr[j]) for (int a = 0; a < 2; a++) for (int b = 0; b < 2; b++) begin
            tm.push_back(tr[j]); ta.push_back(a); tv.push_back(b); tc.push_back(0);
        end
        tm.push_back(2); ta.push_back(1); tv.push_back(0); tc.push_back(1);
        tm.push_back(2); ta.push_back(1); tv.push_back(0); tc.push_back(0);
        tm.push_back(2); ta.push_back(0); tv.push_back(0); tc.push_back(0);
        tm.push_back(2); ta.push_back(1); tv.push_back(0); tc.push_back(0);
        tm.push_back(2); ta.push_back(1); tv.push_back(0); tc.push_back(1);
        n = (wm.size() > tm.size()) ? wm.size() : tm.size();
        for (int i = 0; i < n + 2; i++) begin
            if (i >= 2 && i - 2 < wm.size()) begin
                ev = wq.pop_front();
                checks++; if (w_done !== 1'b1) begin errors++; $display("[TB] FAIL wide_done%0d: got %0b expected 1", i, w_done); end
                checks++; if (w_out !== W2'(ev)) begin errors++; $display("[TB] FAIL wide_out%0d: got %0d expected %0d", i, w_out, ev); end
            end
            if (i >= 2 && i - 2 < tm.size()) begin
                ev = tq.pop_front();
                checks++; if (t_done !== 1'b1) begin errors++; $display("[TB] FAIL p2_done%0d: got %0b expected 1", i, t_done); end
                checks++; if (t_out !== W3'(ev)) begin errors++; $display("[TB] FAIL p2_out%0d: got %0d expected %0d", i, t_out, ev); end
            end
            if (i < wm.size()) begin
                w_start = 1'b1; w_mode = 2'(wm[i]); w_clr = (wc[i] != 0);
                w_a = W2'(wa[i]); w_b = W2'(wb[i]);
                if (wm[i] == 2) begin
                    base = (wc[i] != 0) ? 0 : w_acc;
                    w_acc = (base + wa[i]) % P2; ev = w_acc;
                end else begin
                    ev = ref_op(wm[i], wa[i], wb[i], P2);
                    if (wc[i] != 0) w_acc = 0;
                end
                wq.push_back(ev);
            end else begin
                w_start = 1'b0; w_clr = 1'b0;
            end
            if (i < tm.size()) begin
                t_start = 1'b1; t_mode = 2'(tm[i]); t_clr = (tc[i] != 0);
                t_a = W3'(ta[i]); t_b = W3'(tv[i]);
                if (tm[i] == 2) begin
                    base = (tc[i] != 0) ? 0 : t_acc;
                    t_acc = (base + ta[i]) % P3; ev = t_acc;
                end else begin
                    ev = ref_op(tm[i], ta[i], tv[i], P3);
                    if (tc[i] != 0) t_acc = 0;
                end
                tq.push_back(ev);
            end else begin
                t_start = 1'b0; t_clr = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (w_done !== 1'b0 || t_done !== 1'b0) begin errors++; $display("[TB] FAIL sweep_tail: got %0b %0b expected 0 0", w_done, t_done); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        w_start = 1'b0; w_mode = 2'b00; w_clr = 1'b0; w_a = '0; w_b = '0;
        t_start = 1'b0; t_mode = 2'b00; t_clr = 1'b0; t_a = '0; t_b = '0;
        test_reset();
        test_add();
        test_sub();
        test_negate();
        test_acc_chain();
        test_acc_clr();
        test_back_to_back();
        test_reset_midflight();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
